// File: rtl/ibus_dbus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ibus_dbus_arbiter_pkg
//  Brief    : Shared memory-bus definitions: arbiter FSM states, grant owner
//             encoding and a counter-width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package ibus_dbus_arbiter_pkg;

  // Arbiter FSM: idle, or one requester owns the shared memory port.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_BUSY  = 2'd1,
    ST_LSU_BUSY = 2'd2
  } arb_state_e;

  // Identity of the requester granted the shared port.
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  // Width of a counter that must hold values 0 .. limit-1 (at least 1 bit).
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ibus_dbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ibus_dbus_arbiter
//  Brief    : Round-robin arbiter sharing one memory port between the fetch
//             (IF) and load/store (LSU) buses, with flush-drop handling and
//             an acknowledge timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module ibus_dbus_arbiter
  import ibus_dbus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_kill_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ack_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [DATA_W/8-1:0] lsu_sel_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic                lsu_flush_i,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                lsu_ack_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ack_i,
  output logic                err_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = cnt_width(TIMEOUT);
  // Busy cycle index (0-based) in which an unacknowledged access times out.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e         state_q, state_d;
  arb_owner_e         last_q, last_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [SEL_W-1:0]   mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               w_busy, w_kill, w_timeout, w_done, w_ack;
  logic               w_if_ok, w_lsu_ok;
  arb_owner_e         w_pick;

  // State register: synchronous active-low reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      drop_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
    end
  end

  // Grant selection, completion/timeout detection and combinational acks.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;

    w_busy    = (state_q != ST_IDLE);
    // Only the flush of the current owner matters while busy.
    w_kill    = (state_q == ST_IF_BUSY) ? if_kill_i : lsu_flush_i;
    // A real ack in the last allowed cycle wins over the timeout.
    w_timeout = w_busy && !mem_ack_i && (TIMEOUT > 0) && (cnt_q == CNT_LAST);
    w_done    = w_busy && (mem_ack_i || w_timeout);
    w_ack     = w_done && !drop_q && !w_kill;

    if_ack_o    = w_ack && (state_q == ST_IF_BUSY);
    lsu_ack_o   = w_ack && (state_q == ST_LSU_BUSY);
    // Timed-out completions return zero data; idle outputs never leak data.
    if_rdata_o  = (if_ack_o && mem_ack_i) ? mem_rdata_i : '0;
    lsu_rdata_o = (lsu_ack_o && mem_ack_i) ? mem_rdata_i : '0;
    err_o       = w_timeout;

    w_if_ok  = if_req_i && !if_kill_i;
    w_lsu_ok = lsu_req_i && !lsu_flush_i;
    if (w_if_ok && w_lsu_ok) begin
      w_pick = (last_q == OWN_IF) ? OWN_LSU : OWN_IF;
    end else if (w_lsu_ok) begin
      w_pick = OWN_LSU;
    end else begin
      w_pick = OWN_IF;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_if_ok || w_lsu_ok) begin
          last_d    = w_pick;
          mem_req_d = 1'b1;
          drop_d    = 1'b0;
          cnt_d     = '0;
          if (w_pick == OWN_IF) begin
            state_d     = ST_IF_BUSY;
            mem_we_d    = 1'b0;
            mem_sel_d   = '1;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
          end else begin
            state_d     = ST_LSU_BUSY;
            mem_we_d    = lsu_we_i;
            mem_sel_d   = lsu_sel_i;
            mem_addr_d  = lsu_addr_i;
            mem_wdata_d = lsu_wdata_i;
          end
        end
      end
      ST_IF_BUSY, ST_LSU_BUSY: begin
        if (w_done) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          // The memory access still runs to completion; only the ack is lost.
          drop_d = drop_q | w_kill;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_sel_o   = mem_sel_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ibus_dbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ibus_dbus_arbiter
//  Brief    : Directed scenarios followed by randomized traffic, every cycle
//             compared against a behavioural model of the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ibus_dbus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_i, if_kill_i, if_ack_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          lsu_req_i, lsu_we_i, lsu_flush_i, lsu_ack_o;
  logic [SW-1:0] lsu_sel_i;
  logic [AW-1:0] lsu_addr_i;
  logic [DW-1:0] lsu_wdata_i, lsu_rdata_o;
  logic          mem_req_o, mem_we_o, mem_ack_i, err_o;
  logic [SW-1:0] mem_sel_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  ibus_dbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_sel_i(lsu_sel_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_flush_i(lsu_flush_i),
    .lsu_rdata_o(lsu_rdata_o), .lsu_ack_o(lsu_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: owner 0 = none, 1 = IF, 2 = LSU.
  int            m_owner, m_last, m_wait;
  bit            m_drop;
  logic          m_we;
  logic [SW-1:0] m_sel;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  // Observed activity for scenario-level checks.
  int            n_if_ack = 0, n_lsu_ack = 0, n_err = 0;
  logic [DW-1:0] last_if_rdata, last_lsu_rdata;
  bit            saw_if_ack, saw_lsu_ack;
  int            ack_order[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 1; m_wait = 0; m_drop = 0;
    m_we = 0; m_sel = '0; m_addr = '0; m_wdata = '0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit            tmo, done, kill, e_if, e_lsu, if_ok, lsu_ok;
    logic [DW-1:0] e_if_rd, e_lsu_rd;
    int            pick;
    @(negedge clk);
    tmo   = (m_owner != 0) && !mem_ack_i && (m_wait + 1 == TO);
    done  = (m_owner != 0) && (mem_ack_i || tmo);
    kill  = (m_owner == 1) ? if_kill_i : (m_owner == 2) ? lsu_flush_i : 1'b0;
    e_if  = done && (m_owner == 1) && !m_drop && !kill;
    e_lsu = done && (m_owner == 2) && !m_drop && !kill;
    e_if_rd  = (e_if && mem_ack_i) ? mem_rdata_i : '0;
    e_lsu_rd = (e_lsu && mem_ack_i) ? mem_rdata_i : '0;
    chk("if_ack", if_ack_o, e_if);
    chk("lsu_ack", lsu_ack_o, e_lsu);
    chk("if_rdata", if_rdata_o, e_if_rd);
    chk("lsu_rdata", lsu_rdata_o, e_lsu_rd);
    chk("err", err_o, tmo);
    chk("mem_req", mem_req_o, m_owner != 0);
    chk("mem_we", mem_we_o, m_we);
    chk("mem_sel", mem_sel_o, m_sel);
    chk("mem_addr", mem_addr_o, m_addr);
    chk("mem_wdata", mem_wdata_o, m_wdata);
    saw_if_ack  = if_ack_o;
    saw_lsu_ack = lsu_ack_o;
    if (if_ack_o)  begin n_if_ack++;  last_if_rdata  = if_rdata_o;  ack_order.push_back(1); end
    if (lsu_ack_o) begin n_lsu_ack++; last_lsu_rdata = lsu_rdata_o; ack_order.push_back(2); end
    if (err_o) n_err++;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (m_owner != 0) begin
      if (done) m_owner = 0;
      else begin
        m_wait++;
        m_drop = m_drop | kill;
      end
    end else begin
      if_ok  = if_req_i && !if_kill_i;
      lsu_ok = lsu_req_i && !lsu_flush_i;
      pick = 0;
      if (if_ok && lsu_ok) pick = (m_last == 1) ? 2 : 1;
      else if (if_ok)      pick = 1;
      else if (lsu_ok)     pick = 2;
      if (pick == 1) begin
        m_we = 0; m_sel = '1; m_addr = if_addr_i; m_wdata = '0;
      end else if (pick == 2) begin
        m_we = lsu_we_i; m_sel = lsu_sel_i; m_addr = lsu_addr_i; m_wdata = lsu_wdata_i;
      end
      if (pick != 0) begin
        m_owner = pick; m_last = pick; m_wait = 0; m_drop = 0;
      end
    end
    #1;
  endtask

  initial begin
    int a0, b0, e0, busy_cycles;
    bit if_pend, lsu_pend;
    model_reset();
    rst_n = 0; if_req_i = 0; if_addr_i = '0; if_kill_i = 0;
    lsu_req_i = 0; lsu_we_i = 0; lsu_sel_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
    lsu_flush_i = 0; mem_ack_i = 0; mem_rdata_i = '0;
    repeat (3) tick();
    rst_n = 1;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);

    // IF-only read, memory acks on the third busy cycle.
    if_req_i = 1; if_addr_i = 32'h100;
    tick();
    chk("if_rd_req", mem_req_o, 1);
    chk("if_rd_we", mem_we_o, 0);
    chk("if_rd_sel", mem_sel_o, 4'hF);
    chk("if_rd_addr", mem_addr_o, 32'h100);
    a0 = n_if_ack;
    tick(); tick();
    mem_rdata_i = 32'hDEADBEEF; mem_ack_i = 1;
    tick();
    mem_ack_i = 0; if_req_i = 0;
    tick();
    chk("if_rd_acks", n_if_ack - a0, 1);
    chk("if_rd_data", last_if_rdata, 32'hDEADBEEF);

    // Round-robin from reset: LSU, IF, LSU, IF with both always requesting.
    rst_n = 0; tick(); rst_n = 1;
    ack_order.delete();
    if_req_i = 1; if_addr_i = 32'h400;
    lsu_req_i = 1; lsu_we_i = 0; lsu_sel_i = 4'hF; lsu_addr_i = 32'h300; lsu_wdata_i = '0;
    tick();
    chk("rr_first_addr", mem_addr_o, 32'h300);
    mem_ack_i = 1; tick();
    mem_ack_i = 0; lsu_addr_i = 32'h304; tick();
    chk("rr_second_addr", mem_addr_o, 32'h400);
    mem_ack_i = 1; tick();
    mem_ack_i = 0; if_addr_i = 32'h404; tick();
    chk("rr_third_addr", mem_addr_o, 32'h304);
    mem_ack_i = 1; tick();
    mem_ack_i = 0; lsu_req_i = 0; tick();
    mem_ack_i = 1; tick();
    mem_ack_i = 0; if_req_i = 0; tick();
    chk("rr_count", ack_order.size(), 4);
    if (ack_order.size() == 4) begin
      chk("rr_order0", ack_order[0], 2);
      chk("rr_order1", ack_order[1], 1);
      chk("rr_order2", ack_order[2], 2);
      chk("rr_order3", ack_order[3], 1);
    end

    // Flushed store still completes on the bus without an ack.
    lsu_req_i = 1; lsu_we_i = 1; lsu_sel_i = 4'h3; lsu_addr_i = 32'h200; lsu_wdata_i = 32'h1234;
    tick();
    a0 = n_lsu_ack;
    lsu_flush_i = 1; tick();
    lsu_flush_i = 0; lsu_req_i = 0; tick();
    chk("st_we", mem_we_o, 1);
    chk("st_sel", mem_sel_o, 4'h3);
    chk("st_addr", mem_addr_o, 32'h200);
    chk("st_wdata", mem_wdata_o, 32'h1234);
    chk("st_req", mem_req_o, 1);
    mem_ack_i = 1; tick();
    mem_ack_i = 0;
    chk("st_req_fall", mem_req_o, 0);
    chk("st_no_ack", n_lsu_ack - a0, 0);

    // Timeout: memory never acks.
    lsu_req_i = 1; lsu_we_i = 0; lsu_sel_i = 4'hF; lsu_addr_i = 32'h280;
    mem_rdata_i = 32'hA5A5A5A5;
    tick();
    a0 = n_lsu_ack; e0 = n_err; busy_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req_o) busy_cycles++;
      if (saw_lsu_ack) lsu_req_i = 0;
      tick();
    end
    chk("to_busy_cycles", busy_cycles, TO);
    chk("to_err", n_err - e0, 1);
    chk("to_ack", n_lsu_ack - a0, 1);
    chk("to_rdata", last_lsu_rdata, 0);
    chk("to_req_low", mem_req_o, 0);

    // Reset during LSU busy abandons the transaction.
    lsu_req_i = 1; lsu_addr_i = 32'h500;
    tick();
    tick();
    a0 = n_lsu_ack;
    rst_n = 0; tick();
    rst_n = 1; lsu_req_i = 0;
    chk("rst_busy_req", mem_req_o, 0);
    chk("rst_busy_addr", mem_addr_o, 0);
    tick();
    chk("rst_busy_noack", n_lsu_ack - a0, 0);
    b0 = n_if_ack;
    if_req_i = 1; if_addr_i = 32'h600;
    tick();
    chk("post_rst_addr", mem_addr_o, 32'h600);
    mem_ack_i = 1; mem_rdata_i = 32'h600DF00D; tick();
    mem_ack_i = 0; if_req_i = 0; tick();
    chk("post_rst_ack", n_if_ack - b0, 1);
    chk("post_rst_data", last_if_rdata, 32'h600DF00D);

    // Randomized traffic against the model.
    if_pend = 0; lsu_pend = 0; e0 = n_err; a0 = n_if_ack; b0 = n_lsu_ack;
    for (int c = 0; c < 3000; c++) begin
      if (saw_if_ack || if_kill_i) if_pend = 0;
      if (saw_lsu_ack || lsu_flush_i) lsu_pend = 0;
      if_kill_i   = ($urandom_range(0, 19) == 0);
      lsu_flush_i = ($urandom_range(0, 19) == 0);
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_addr_i = $urandom;
      end
      if (!lsu_pend && $urandom_range(0, 2) == 0) begin
        lsu_pend = 1; lsu_we_i = 1'($urandom_range(0, 1));
        lsu_sel_i = 4'($urandom_range(1, 15));
        lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
      end
      if_req_i  = if_pend;
      lsu_req_i = lsu_pend;
      mem_ack_i = (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mem_rdata_i = $urandom;
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    chk("rand_err_seen", n_err > e0, 1);
    chk("rand_if_seen", n_if_ack > a0, 1);
    chk("rand_lsu_seen", n_lsu_ack > b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
